// File: rtl/shift_sequencer.sv
// Command-driven sequencer for a 4-bit universal shift register.
// Each command loads a value, applies one shift op a programmed number of times, then returns Q.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_op,
  input  logic [CNT_W-1:0] i_cmd_count,
  input  logic [WIDTH-1:0] i_cmd_data,
  output logic [2:0]       o_sel,
  output logic [WIDTH-1:0] o_load_data,
  input  logic [WIDTH-1:0] i_q,
  output logic             o_busy,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_data
);

  // state   | meaning
  // S_IDLE  | shifter holds, waiting for a command
  // S_LOAD  | Sel=LOAD, shifter captures the command data
  // S_SHIFT | Sel=op, one shift per edge until remaining reaches 1
  // S_DONE  | shifter holds, result offered until consumer accepts

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_HLD  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd7;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_remaining;
  logic [2:0]       r_sel;
  logic [WIDTH-1:0] r_load_data;
  logic             r_res_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_HLD;
      r_count     <= '0;
      r_remaining <= '0;
      r_sel       <= OP_HLD;
      r_load_data <= '0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sel <= OP_HLD;
          if (i_cmd_valid) begin
            r_op        <= i_cmd_op;
            r_count     <= i_cmd_count;
            r_load_data <= i_cmd_data;
            r_sel       <= OP_LOAD;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_op == OP_LOAD || r_count == '0) begin
            r_sel       <= OP_HLD;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_sel       <= r_op;
            r_remaining <= r_count;
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_remaining <= r_remaining - CNT_W'(1);
          // The last shift happens on this same edge, so Sel drops to hold now.
          if (r_remaining == CNT_W'(1)) begin
            r_sel       <= OP_HLD;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_sel       <= OP_HLD;
          r_res_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_sel       = r_sel;
  assign o_load_data = r_load_data;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = i_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioural shifter on Q, directed plan cases plus random commands
// checked against a closed-form shift reference.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_count;
  logic [3:0] cmd_data;
  logic [2:0] sel;
  logic [3:0] load_data;
  logic [3:0] q;
  logic       busy;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_count (cmd_count),
    .i_cmd_data  (cmd_data),
    .o_sel       (sel),
    .o_load_data (load_data),
    .i_q         (q),
    .o_busy      (busy),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_data  (res_data)
  );

  // Universal shift register; deliberately never reset.
  always @(posedge clk) begin
    case (sel)
      3'd1: q <= {q[0], q[3:1]};
      3'd2: q <= {q[2:0], q[3]};
      3'd3: q <= {1'b0, q[3:1]};
      3'd4: q <= {q[2:0], 1'b0};
      3'd5: q <= {q[3], q[3:1]};
      3'd6: q <= {q[2:0], 1'b0};
      3'd7: q <= load_data;
      default: q <= q;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Value after applying op n times to d, in closed form.
  function automatic logic [3:0] ref_result(input logic [2:0] op, input int n, input logic [3:0] d);
    int v = int'(d);
    int s;
    int k = n % 4;
    int r;
    case (op)
      3'd1: r = ((v >> k) | (v << (4 - k))) & 15;
      3'd2: r = ((v << k) | (v >> (4 - k))) & 15;
      3'd3: r = (n >= 4) ? 0 : (v >> n);
      3'd4, 3'd6: r = (v << n) & 15;
      3'd5: begin
        s = (v >= 8) ? v - 16 : v;
        r = (s >>> n) & 15;
      end
      default: r = v;
    endcase
    return r[3:0];
  endfunction

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_cmd(input logic [2:0] op, input int cnt, input logic [3:0] data,
                         input int stall, input bit noise);
    int nsh = (op == 3'd7 || cnt == 0) ? 0 : cnt;
    logic [3:0] exp = ref_result(op, cnt, data);
    check("cmd_ready_idle", cmd_ready, 1);
    check("sel_idle", sel, 0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt[2:0];
    cmd_data  = data;
    @(posedge clk); #1;
    cmd_valid = noise;
    cmd_op    = 3'($urandom);
    cmd_count = 3'($urandom);
    cmd_data  = 4'($urandom);
    check("load_data", load_data, data);
    for (int i = 0; i <= nsh; i++) begin
      check("sel_seq", sel, (i == 0) ? 3'd7 : op);
      check("busy", busy, 1);
      check("cmd_ready_busy", cmd_ready, 0);
      check("res_valid_early", res_valid, 0);
      if (i >= 1) check("q_step", res_data, ref_result(op, i - 1, data));
      @(posedge clk); #1;
    end
    for (int s = 0; s <= stall; s++) begin
      check("res_valid", res_valid, 1);
      check("res_data", res_data, exp);
      check("sel_done", sel, 0);
      check("cmd_ready_done", cmd_ready, 0);
      if (s == stall) res_ready = 1'b1;
      @(posedge clk); #1;
    end
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    check("res_valid_drained", res_valid, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    logic [3:0] rdata;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_count = 3'd0;
    cmd_data  = 4'd0;
    res_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", sel, 0);
    check("rst_load_data", load_data, 0);
    check("rst_res_valid", res_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_sel", sel, 0);
    check("idle_res_valid", res_valid, 0);

    run_cmd(3'd1, 4, 4'b1001, 0, 1'b0);
    run_cmd(3'd2, 1, 4'b1000, 0, 1'b0);
    run_cmd(3'd5, 2, 4'b1010, 0, 1'b0);
    run_cmd(3'd6, 3, 4'b1001, 0, 1'b0);
    run_cmd(3'd4, 0, 4'b0011, 0, 1'b0);
    run_cmd(3'd7, 5, 4'b0110, 0, 1'b0);
    run_cmd(3'd3, 2, 4'b1100, 5, 1'b1);
    run_cmd(3'd0, 3, 4'b0101, 1, 1'b0);
    run_cmd(3'd4, 7, 4'b0001, 0, 1'b0);

    // Zero-wait drain with Res_Ready held high throughout.
    res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_count = 3'd1; cmd_data = 4'b1000;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("zw_res_valid", res_valid, 1);
    check("zw_res_data", res_data, 4'b0100);
    @(posedge clk); #1;
    check("zw_drained", res_valid, 0);
    res_ready = 1'b0;

    // Asynchronous reset in the middle of a shift sequence.
    rdata = 4'($urandom);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_count = 3'd7; cmd_data = rdata;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sel", sel, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_load_data", load_data, 0);
    check("mid_rst_q_kept", res_data, ref_result(3'd1, 3, rdata));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmd(3'd2, 2, 4'b0001, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      run_cmd(3'($urandom), int'($urandom_range(0, 7)), 4'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command-driven controller for the 4-bit universal shift register (select S[2:0], parallel load L, output Q).
- Accepts one command per transaction over a valid/ready handshake: load a value, then apply one shift op a programmed number of times.
- Drives the shifter's select and load inputs cycle by cycle, then returns the final Q over a result handshake.
- Sits between a requesting unit and a single shifter instance, so shift sequences no longer need per-cycle S toggling.

Parameters:
- WIDTH, 4, shifter data width; sets LoadData, Q and the data fields.
- CNT_W, 3, width of the shift-count field (max 2^CNT_W-1 shifts per command).

Ports:
- Clock  input  1  rising-edge clock, shared with the shifter.
- Reset_n  input  1  asynchronous active-low reset.
- Cmd_Valid  input  1  command present.
- Cmd_Ready  output  1  controller can accept a command.
- Cmd_Op  input  3  shift op in shifter encoding: 0 HLD, 1 CSR, 2 CSL, 3 LSR, 4 LSL, 5 ASR, 6 ASL, 7 LOAD-only.
- Cmd_Count  input  CNT_W  number of shift cycles to apply.
- Cmd_Data  input  WIDTH  value loaded into the shifter before shifting.
- Sel  output  3  to shifter S.
- LoadData  output  WIDTH  to shifter L.
- Q  input  WIDTH  shifter output.
- Busy  output  1  high in any state except IDLE.
- Res_Valid  output  1  result available.
- Res_Ready  input  1  consumer accepts result.
- Res_Data  output  WIDTH  final shifter value.

Behaviour:
- **Registers.** Sel, LoadData, Res_Valid and the state are registered. Cmd_Ready = (state==IDLE). Busy = (state!=IDLE). Res_Data = Q, passed through combinationally.
- **Reset (async, Reset_n low).**
  - state=IDLE, Sel=0 (HLD), LoadData=0, Res_Valid=0, remaining-count=0.
  - The shifter register itself is not reset; its content is undefined until the first LOAD.
- **IDLE:** Sel=0.
  - Accept on rising edge E0 when Cmd_Valid && Cmd_Ready.
  - Latch op, count and data. Sel<=7, LoadData<=Cmd_Data, go LOAD.
- **LOAD** (Sel=7 during the cycle; the shifter loads at edge E1):
  - Op==7 or count==0: Sel<=0, Res_Valid<=1, go DONE.
  - Otherwise: Sel<=op, remaining<=count, go SHIFT.
- **SHIFT** (Sel=op; the shifter shifts on every edge):
  - Each edge: remaining<=remaining-1.
  - At the edge where remaining==1: Sel<=0, Res_Valid<=1, go DONE.
  - Exactly count shifts occur, at edges E2..E(1+count).
- **DONE:** Sel=0, so Q holds; Res_Valid=1, Cmd_Ready=0.
  - On an edge with Res_Ready=1: Res_Valid<=0, go IDLE.
  - The next command can be accepted on the edge after that; no command is accepted in DONE.
- **Latency:**
  - Res_Valid rises after edge E(1+count) when count>0, i.e. count+1 cycles after accept.
  - Res_Valid rises after E1 when count==0 or op==7.
- **Op 0 with count N:** N hold cycles; the result equals the loaded data.
- **Handshake inputs:**
  - Cmd_* fields are sampled only at the accept edge; later changes are ignored.
  - Cmd_Valid while busy is ignored; the command is not queued.
- **Res_Ready:** may be held high continuously (zero-wait drain). When low, Res_Valid and Res_Data stay stable indefinitely.
- **Count wrap:** none. remaining never decrements below 1 in SHIFT. The maximum count (7 at default) gives 7 shifts.
- **Reset mid-operation** (LOAD/SHIFT/DONE):
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - Any pending result is discarded.
  - Q keeps whatever the shifter last captured.
- **Sel glitch-free:** Sel changes only on clock edges or on reset assertion.

Test Plan:
1. Reset then idle → Sel=000, LoadData=0000, Cmd_Ready=1, Busy=0, Res_Valid=0.
2. Cmd Op=1 (CSR), Count=4, Data=1001:
   - Sel=111 for one cycle, then 001 for 4 cycles.
   - Res_Valid high 5 cycles after accept, Res_Data=1001.
   - Intermediate Q values 1100, 0110, 0011, 1001.
3. Op=2 (CSL), Count=1, Data=1000 → Res_Data=0001. Then Op=5 (ASR), Count=2, Data=1010 → Res_Data=1110. Then Op=6 (ASL), Count=3, Data=1001 → Res_Data=1000.
4. Op=4 (LSL), Count=0, Data=0011, and Op=7, Count=5, Data=0110:
   - Res_Valid 1 cycle after accept.
   - Results 0011 and 0110 respectively; no shift-select cycles are issued.
5. Backpressure: Op=3 (LSR), Count=2, Data=1100, Res_Ready=0 for 5 cycles.
   - Res_Valid=1 and Res_Data=0011 held stable throughout.
   - Cmd_Ready=0 while a second Cmd_Valid is asserted; the second command is accepted only after the result is drained.
6. Reset_n pulsed low mid-SHIFT (Op=1, Count=7, after 3 shifts):
   - Immediately Sel=000, Res_Valid=0, Busy=0.
   - After release, a new command Op=2, Count=2, Data=0001 completes with Res_Data=0100.
